// File: rtl/bin2bcd_pkg.sv
// Shared types and default sizing for the binary-to-BCD converter.
// Defaults suit a 20-bit Fibonacci result rendered as 7 decimal digits.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_BIN_W = 20;
  localparam int DEF_N_DIG = 7;

endpackage

// File: rtl/bin2bcd_conv_if.sv
// Request/result bundle between a binary producer and the BCD converter.
interface bin2bcd_conv_if
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = DEF_BIN_W,
  parameter int N_DIG = DEF_N_DIG
) ();

  logic                 start;
  logic [BIN_W-1:0]     bin;
  logic                 ready;
  logic                 done_tick;
  logic [4*N_DIG-1:0]   bcd;

  modport master (
    output start,
    output bin,
    input  ready,
    input  done_tick,
    input  bcd
  );

  modport slave (
    input  start,
    input  bin,
    output ready,
    output done_tick,
    output bcd
  );

endinterface

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_adj3 (
  input  logic [3:0] i_dig,
  output logic [3:0] o_dig
);

  assign o_dig = (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter: one iteration per clock,
// result published on bcd only when the last shift completes.
module bin2bcd_conv
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = DEF_BIN_W,
  parameter int N_DIG = DEF_N_DIG
) (
  input  logic           clk,
  input  logic           rst,
  bin2bcd_conv_if.slave  bus
);

  localparam int BCD_W = 4 * N_DIG;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int CAT_W = BCD_W + BIN_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_next;
  logic [BIN_W-1:0]   r_shift, w_shift_next;
  logic [BCD_W-1:0]   r_work,  w_work_next;
  logic [BCD_W-1:0]   r_bcd,   w_bcd_next;
  logic               r_ready, w_ready_next;
  logic               r_done,  w_done_next;

  logic [BCD_W-1:0]   w_adj;
  logic [CAT_W-1:0]   w_cat;

  for (genvar gi = 0; gi < N_DIG; gi++) begin : g_adj
    bcd_adj3 u_adj (
      .i_dig (r_work[4*gi +: 4]),
      .o_dig (w_adj[4*gi +: 4])
    );
  end

  // Adjust happens on the current digits, then the combined register shifts.
  assign w_cat = {w_adj, r_shift} << 1;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    w_work_next  = r_work;
    w_bcd_next   = r_bcd;
    w_ready_next = r_ready;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready_next = 1'b1;
        if (bus.start) begin
          w_state_next = OP;
          w_shift_next = bus.bin;
          w_work_next  = '0;
          w_cnt_next   = CNT_LOAD;
          w_ready_next = 1'b0;
        end
      end
      OP: begin
        w_work_next  = w_cat[CAT_W-1:BIN_W];
        w_shift_next = w_cat[BIN_W-1:0];
        w_cnt_next   = r_cnt - CNT_ONE;
        w_ready_next = 1'b0;
        if (r_cnt == CNT_ONE) begin
          w_state_next = DONE;
          w_bcd_next   = w_cat[CAT_W-1:BIN_W];
          w_done_next  = 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
        w_ready_next = 1'b1;
      end
      default: begin
        w_state_next = IDLE;
        w_ready_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_cnt_next;
  end

  always_ff @(posedge clk) begin
    if (rst) r_shift <= '0;
    else     r_shift <= w_shift_next;
  end

  always_ff @(posedge clk) begin
    if (rst) r_work <= '0;
    else     r_work <= w_work_next;
  end

  always_ff @(posedge clk) begin
    if (rst) r_bcd <= '0;
    else     r_bcd <= w_bcd_next;
  end

  always_ff @(posedge clk) begin
    if (rst) r_ready <= 1'b1;
    else     r_ready <= w_ready_next;
  end

  always_ff @(posedge clk) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= w_done_next;
  end

  assign bus.ready     = r_ready;
  assign bus.done_tick = r_done;
  assign bus.bcd       = r_bcd;

endmodule
